// File: rtl/puf_challenge_requester.sv
// Host-side requester for a PUF wrapper: latches challenge/helper, pulses INPUT_READY, waits for DONE edge.
// Optional wait timeout enabled by defining PUF_REQ_TIMEOUT_EN.
module puf_challenge_requester #(
    parameter int unsigned CHALLENGE_SIZE   = 32,
    parameter int unsigned RESPONSE_SIZE    = 256,
    parameter int unsigned HELPER_DATA_SIZE = 96,
    parameter int unsigned TIMEOUT_CYCLES   = 1024
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          REQ_VALID,
    output logic                          REQ_READY,
    input  logic [CHALLENGE_SIZE-1:0]     REQ_CHALLENGE,
    input  logic [0:HELPER_DATA_SIZE-1]   REQ_HELPER,
    output logic [CHALLENGE_SIZE-1:0]     CHALLENGE,
    output logic [0:HELPER_DATA_SIZE-1]   HELPER_DATA,
    output logic                          INPUT_READY,
    input  logic [RESPONSE_SIZE-1:0]      PUF_RESPONSE,
    input  logic                          DONE,
    output logic                          RSP_VALID,
    input  logic                          RSP_READY,
    output logic [RESPONSE_SIZE-1:0]      RSP_DATA,
    output logic                          RSP_TIMEOUT
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_timeout_range
        $error("TIMEOUT_CYCLES must be in 2..65535");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t                        state_q, state_d;
    logic                          req_ready_q, req_ready_d;
    logic                          input_ready_q, input_ready_d;
    logic                          rsp_valid_q, rsp_valid_d;
    logic [RESPONSE_SIZE-1:0]      rsp_data_q, rsp_data_d;
    logic [CHALLENGE_SIZE-1:0]     challenge_q, challenge_d;
    logic [0:HELPER_DATA_SIZE-1]   helper_q, helper_d;
    logic                          done_q, done_d;
    logic                          completion;

`ifdef PUF_REQ_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0]                   cnt_q, cnt_d;
    logic                          rsp_timeout_q, rsp_timeout_d;
`endif

    // Only a fresh rising edge counts; a level left high by the previous run is ignored.
    assign completion = DONE && !done_q;

    always_comb begin
        state_d     = state_q;
        rsp_data_d  = rsp_data_q;
        challenge_d = challenge_q;
        helper_d    = helper_q;
        done_d      = DONE;
`ifdef PUF_REQ_TIMEOUT_EN
        cnt_d         = cnt_q;
        rsp_timeout_d = rsp_timeout_q;
`endif
        case (state_q)
            IDLE: begin
                if (REQ_VALID && req_ready_q) begin
                    challenge_d = REQ_CHALLENGE;
                    helper_d    = REQ_HELPER;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef PUF_REQ_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
                if (completion) begin
                    rsp_data_d    = PUF_RESPONSE;
`ifdef PUF_REQ_TIMEOUT_EN
                    rsp_timeout_d = 1'b0;
`endif
                    state_d       = HOLD;
                end
`ifdef PUF_REQ_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_LAST) begin
                    rsp_data_d    = '0;
                    rsp_timeout_d = 1'b1;
                    state_d       = HOLD;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            HOLD: begin
                if (RSP_READY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Handshake outputs are registered copies of the next-state decode.
        req_ready_d   = (state_d == IDLE);
        input_ready_d = (state_d == ISSUE);
        rsp_valid_d   = (state_d == HOLD);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= IDLE;
            req_ready_q   <= 1'b0;
            input_ready_q <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            challenge_q   <= '0;
            helper_q      <= '0;
            done_q        <= 1'b0;
`ifdef PUF_REQ_TIMEOUT_EN
            cnt_q         <= '0;
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            req_ready_q   <= req_ready_d;
            input_ready_q <= input_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            challenge_q   <= challenge_d;
            helper_q      <= helper_d;
            done_q        <= done_d;
`ifdef PUF_REQ_TIMEOUT_EN
            cnt_q         <= cnt_d;
            rsp_timeout_q <= rsp_timeout_d;
`endif
        end
    end

    assign REQ_READY   = req_ready_q;
    assign INPUT_READY = input_ready_q;
    assign RSP_VALID   = rsp_valid_q;
    assign RSP_DATA    = rsp_data_q;
    assign CHALLENGE   = challenge_q;
    assign HELPER_DATA = helper_q;
`ifdef PUF_REQ_TIMEOUT_EN
    assign RSP_TIMEOUT = rsp_timeout_q;
`else
    assign RSP_TIMEOUT = 1'b0;
`endif

endmodule

// File: doc/puf_challenge_requester.md
PUF_CHALLENGE_REQUESTER -- requirements
Module: puf_challenge_requester

Interface
REQ-001 SHALL have parameter CHALLENGE_SIZE, default 32: challenge width in bits.
REQ-002 SHALL have parameter RESPONSE_SIZE, default 256: PUF response width in bits.
REQ-003 SHALL have parameter HELPER_DATA_SIZE, default 96: helper data width in bits.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024: maximum number of WAIT cycles, range 2..65535.
REQ-005 SHALL have port CLK  input  1  single clock; all logic samples on its rising edge.
REQ-006 SHALL have port RST  input  1  reset; synchronous, active-high.
REQ-007 SHALL have port REQ_VALID  input  1  host offers a challenge.
REQ-008 SHALL have port REQ_READY  output  1  requester accepts a challenge.
REQ-009 SHALL have port REQ_CHALLENGE  input  CHALLENGE_SIZE  host challenge.
REQ-010 SHALL have port REQ_HELPER  input  HELPER_DATA_SIZE  host helper data, bit order [0:HELPER_DATA_SIZE-1].
REQ-011 SHALL have port CHALLENGE  output  CHALLENGE_SIZE  challenge to the PUF wrapper.
REQ-012 SHALL have port HELPER_DATA  output  HELPER_DATA_SIZE  helper data to the PUF wrapper, bit order [0:HELPER_DATA_SIZE-1].
REQ-013 SHALL have port INPUT_READY  output  1  start pulse to the PUF wrapper.
REQ-014 SHALL have port PUF_RESPONSE  input  RESPONSE_SIZE  response from the PUF wrapper.
REQ-015 SHALL have port DONE  input  1  level completion flag from the PUF wrapper.
REQ-016 SHALL have port RSP_VALID  output  1  result available to host.
REQ-017 SHALL have port RSP_READY  input  1  host consumes result.
REQ-018 SHALL have port RSP_DATA  output  RESPONSE_SIZE  captured response.
REQ-019 SHALL have port RSP_TIMEOUT  output  1  result is a timeout, RSP_DATA is zero.

Function
REQ-020 SHALL implement states IDLE, ISSUE, WAIT, HOLD.
REQ-021 SHALL assert REQ_READY only in IDLE; REQ_VALID&&REQ_READY latches REQ_CHALLENGE/REQ_HELPER into CHALLENGE/HELPER_DATA and moves to ISSUE.
REQ-022 SHALL drive INPUT_READY high for exactly one cycle, the cycle in ISSUE, then move to WAIT.
REQ-023 SHALL hold CHALLENGE and HELPER_DATA constant from the ISSUE cycle until the next accepted request.
REQ-024 SHALL register DONE each cycle (done_q) and treat DONE&&!done_q as completion; a DONE level still high from a prior transaction is not completion.
REQ-025 SHALL, on completion in WAIT, capture PUF_RESPONSE into RSP_DATA, clear RSP_TIMEOUT, move to HOLD; RSP_VALID high the following cycle.
REQ-026 SHALL count WAIT cycles in a 16-bit counter cleared on entry to WAIT; reaching TIMEOUT_CYCLES without completion moves to HOLD with RSP_DATA=0, RSP_TIMEOUT=1.
REQ-027 SHALL give completion priority when completion and timeout occur in the same cycle.
REQ-028 SHALL hold RSP_VALID, RSP_DATA, RSP_TIMEOUT stable in HOLD until RSP_READY; RSP_VALID&&RSP_READY returns to IDLE, RSP_VALID low next cycle.
REQ-029 SHALL ignore REQ_VALID outside IDLE and ignore DONE outside WAIT (done_q still updates).
REQ-030 SHALL minimum request-to-RSP_VALID latency be 3 cycles (accept, ISSUE, WAIT with completion).

Reset
REQ-031 SHALL, when RST is high at a clock edge, go to IDLE and set REQ_READY=0 for that cycle, INPUT_READY=0, RSP_VALID=0, RSP_TIMEOUT=0, RSP_DATA=0, CHALLENGE=0, HELPER_DATA=0, done_q=0, counter=0.
REQ-032 SHALL abandon any in-flight transaction on RST mid-operation with no RSP_VALID produced for it.

Configuration
REQ-033 SHALL, with macro PUF_REQ_TIMEOUT_EN defined, implement the counter and timeout of REQ-026/027.
REQ-034 SHALL, without PUF_REQ_TIMEOUT_EN, omit the counter, wait in WAIT indefinitely, and tie RSP_TIMEOUT to 0.

Verification
REQ-035 SHALL cover: REQ_CHALLENGE=32'hA5A5_0001 accepted, DONE rises 10 cycles after INPUT_READY with PUF_RESPONSE=256'h1234 -> one INPUT_READY pulse, RSP_DATA=256'h1234, RSP_TIMEOUT=0.
REQ-036 SHALL cover: DONE held high from prior run when new request issued, falls 1 cycle after INPUT_READY, rises 5 cycles later -> capture only on second rise.
REQ-037 SHALL cover: TIMEOUT_CYCLES=16, DONE never rises -> RSP_VALID after 16 WAIT cycles, RSP_TIMEOUT=1, RSP_DATA=0 (macro defined); no RSP_VALID (macro undefined).
REQ-038 SHALL cover: RSP_READY low 20 cycles in HOLD, REQ_VALID high throughout -> RSP outputs stable, REQ_READY=0, no second INPUT_READY.
REQ-039 SHALL cover: RST asserted 3 cycles into WAIT, then DONE rises -> IDLE, all outputs per REQ-031, no RSP_VALID.
REQ-040 SHALL cover: DONE rise on exactly cycle TIMEOUT_CYCLES of WAIT -> RSP_TIMEOUT=0, RSP_DATA=PUF_RESPONSE.
